// File: rtl/wm8731_pkg.sv
// Shared types and constants for the WM8731 power-up configuration controller.
// Command ROM, device address and the START/STOP bus waveforms live here.
package wm8731_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam int NUM_CMD = 7;

    localparam logic [6:0] DEV_ADDR_DEF = 7'h1A;

    // Packed so that element 0 (codec reset) sits in the low word.
    localparam logic [NUM_CMD-1:0][15:0] CMD_ROM = {
        16'h1201,   // active
        16'h1019,   // sampling
        16'h0E42,   // interface: master, I2S, 16-bit
        16'h0C00,   // power
        16'h0A00,   // digital path
        16'h0815,   // analog path
        16'h1E00    // reset
    };

    // Quarter waveforms, bit index = quarter number q.
    localparam logic [3:0] START_SCL = 4'b0111;
    localparam logic [3:0] START_OE  = 4'b1110;
    localparam logic [3:0] STOP_SCL  = 4'b1110;
    localparam logic [3:0] STOP_OE   = 4'b0011;
    localparam logic [3:0] BIT_SCL   = 4'b0110;

endpackage

// File: rtl/wm8731_i2c_init_tick_gen.sv
// Quarter-bit timebase: one-cycle tick every CLK_DIV clocks, restartable.
module i2c_tick_gen #(
    parameter int CLK_DIV = 30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_reg;
    logic          wrap;

    assign wrap = (cnt_reg == CW'(CLK_DIV - 1));
    assign tick = wrap && !restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (restart || wrap) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/wm8731_i2c_init.sv
// WM8731 power-up sequencer: writes the command ROM over I2C, retrying NACKed
// frames, then raises done (and a sticky ack_err if a command gave up).
module wm8731_i2c_init
    import wm8731_pkg::*;
#(
    parameter int         CLK_DIV   = 30,
    parameter int         GAP_Q     = 8,
    parameter int         MAX_RETRY = 3,
    parameter logic [6:0] DEV_ADDR  = DEV_ADDR_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic i2c_sclk,
    output logic i2c_sdat_oe,
    input  logic i2c_sdat_in,
    output logic busy,
    output logic done,
    output logic ack_err
);

    localparam int GW = $clog2(GAP_Q + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    state_t        state_reg, state_next;
    logic [1:0]    q_reg, q_next;
    logic [1:0]    byte_reg, byte_next;
    logic [2:0]    bit_reg, bit_next;
    logic [2:0]    idx_reg, idx_next;
    logic [RW-1:0] retry_reg, retry_next;
    logic [GW-1:0] gap_reg, gap_next;
    logic          nack_reg, nack_next;
    logic          fail_reg, fail_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          ack_err_reg, ack_err_next;
    logic [1:0]    sdat_sync_reg;

    logic       tick;
    logic       start_ok;
    logic [7:0] cur_byte;

    assign start_ok = start && (state_reg == ST_IDLE || state_reg == ST_DONE);

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (start_ok),
        .tick    (tick)
    );

    always_comb begin
        case (byte_reg)
            2'd0:    cur_byte = {DEV_ADDR, 1'b0};
            2'd1:    cur_byte = CMD_ROM[idx_reg][15:8];
            default: cur_byte = CMD_ROM[idx_reg][7:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            q_reg         <= '0;
            byte_reg      <= '0;
            bit_reg       <= '0;
            idx_reg       <= '0;
            retry_reg     <= '0;
            gap_reg       <= '0;
            nack_reg      <= 1'b0;
            fail_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            ack_err_reg   <= 1'b0;
            sdat_sync_reg <= 2'b11;
        end else begin
            state_reg     <= state_next;
            q_reg         <= q_next;
            byte_reg      <= byte_next;
            bit_reg       <= bit_next;
            idx_reg       <= idx_next;
            retry_reg     <= retry_next;
            gap_reg       <= gap_next;
            nack_reg      <= nack_next;
            fail_reg      <= fail_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            ack_err_reg   <= ack_err_next;
            sdat_sync_reg <= {sdat_sync_reg[0], i2c_sdat_in};
        end
    end

    always_comb begin
        state_next   = state_reg;
        q_next       = q_reg;
        byte_next    = byte_reg;
        bit_next     = bit_reg;
        idx_next     = idx_reg;
        retry_next   = retry_reg;
        gap_next     = gap_reg;
        nack_next    = nack_reg;
        fail_next    = fail_reg;
        busy_next    = busy_reg;
        done_next    = done_reg;
        ack_err_next = ack_err_reg;

        if (state_reg == ST_DONE) begin
            busy_next = 1'b0;
            done_next = 1'b1;
        end

        if (start_ok) begin
            state_next   = ST_START;
            q_next       = '0;
            idx_next     = '0;
            retry_next   = '0;
            busy_next    = 1'b1;
            done_next    = 1'b0;
            ack_err_next = 1'b0;
        end else if (tick) begin
            q_next = q_reg + 2'd1;
            case (state_reg)
                ST_START: begin
                    if (q_reg == 2'd3) begin
                        state_next = ST_BIT;
                        byte_next  = 2'd0;
                        bit_next   = 3'd7;
                    end
                end
                ST_BIT: begin
                    if (q_reg == 2'd3) begin
                        if (bit_reg == 3'd0) state_next = ST_ACK;
                        else                 bit_next   = bit_reg - 3'd1;
                    end
                end
                ST_ACK: begin
                    if (q_reg == 2'd2) nack_next = sdat_sync_reg[1];
                    if (q_reg == 2'd3) begin
                        if (nack_reg) begin
                            state_next = ST_STOP;
                            fail_next  = 1'b1;
                        end else if (byte_reg == 2'd2) begin
                            state_next = ST_STOP;
                            fail_next  = 1'b0;
                        end else begin
                            state_next = ST_BIT;
                            byte_next  = byte_reg + 2'd1;
                            bit_next   = 3'd7;
                        end
                    end
                end
                ST_STOP: begin
                    if (q_reg == 2'd3) begin
                        state_next = ST_GAP;
                        gap_next   = '0;
                    end
                end
                ST_GAP: begin
                    if (gap_reg == GW'(GAP_Q - 1)) begin
                        // GAP_Q need not be a multiple of four, so realign q.
                        q_next = '0;
                        if (!fail_reg) begin
                            retry_next = '0;
                            if (idx_reg == 3'(NUM_CMD - 1)) begin
                                state_next = ST_DONE;
                            end else begin
                                idx_next   = idx_reg + 3'd1;
                                state_next = ST_START;
                            end
                        end else if (retry_reg < RW'(MAX_RETRY - 1)) begin
                            retry_next = retry_reg + 1'b1;
                            state_next = ST_START;
                        end else begin
                            ack_err_next = 1'b1;
                            state_next   = ST_DONE;
                        end
                    end else begin
                        gap_next = gap_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus pins decode straight from state so an asynchronous reset releases them at once.
    always_comb begin
        i2c_sclk    = 1'b1;
        i2c_sdat_oe = 1'b0;
        case (state_reg)
            ST_START: begin
                i2c_sclk    = START_SCL[q_reg];
                i2c_sdat_oe = START_OE[q_reg];
            end
            ST_BIT: begin
                i2c_sclk    = BIT_SCL[q_reg];
                i2c_sdat_oe = ~cur_byte[bit_reg];
            end
            ST_ACK: begin
                i2c_sclk    = BIT_SCL[q_reg];
            end
            ST_STOP: begin
                i2c_sclk    = STOP_SCL[q_reg];
                i2c_sdat_oe = STOP_OE[q_reg];
            end
            default: ;
        endcase
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign ack_err = ack_err_reg;

endmodule

// File: tb/tb_wm8731_i2c_init.sv
// Bench for wm8731_i2c_init: I2C slave/decoder model with protocol checks and a
// frame scoreboard, driven from a table of scenarios plus a mid-frame reset case.
`timescale 1ns/1ps
module tb_wm8731_i2c_init;

    localparam int CLK_DIV = 2;
    localparam int GAP_Q   = 8;
    localparam int TMO     = 4000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic i2c_sclk, i2c_sdat_oe, i2c_sdat_in;
    logic busy, done, ack_err;
    logic slave_pull = 1'b0;

    always #5 clk = ~clk;

    // Open-drain line: low if either master or slave pulls.
    assign i2c_sdat_in = ~(i2c_sdat_oe | slave_pull);

    wm8731_i2c_init #(
        .CLK_DIV   (CLK_DIV),
        .GAP_Q     (GAP_Q),
        .MAX_RETRY (3),
        .DEV_ADDR  (7'h1A)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .i2c_sclk    (i2c_sclk),
        .i2c_sdat_oe (i2c_sdat_oe),
        .i2c_sdat_in (i2c_sdat_in),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err)
    );

    typedef struct {
        int   nack_mode;   // 0 ack all, 1 nack byte 1 of frame 2 once, 2 always nack address
        int   poke_frame;  // frame index during which start is re-pulsed, -1 for none
        int   exp_done;    // cycles from start edge until done is seen high
        logic exp_err;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] cmd_tab [7] = '{16'h1E00, 16'h0815, 16'h0A00, 16'h0C00,
                                 16'h0E42, 16'h1019, 16'h1201};
    logic [25:0] exp_q [$];

    bit   mon_en = 1'b0;
    int   nack_mode = 0;
    bit   nack_used = 1'b0;
    int   frames = 0;
    int   bit_cnt = 0;
    int   nbytes = 0;
    bit   in_frame = 1'b0;

    task automatic check_val(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    function automatic logic [25:0] mk_frame(input int i, input int n);
        logic [15:0] c;
        logic [7:0]  b1, b2;
        c  = cmd_tab[i];
        b1 = (n > 1) ? c[15:8] : 8'h00;
        b2 = (n > 2) ? c[7:0]  : 8'h00;
        return {2'(n), 8'h34, b1, b2};
    endfunction

    task automatic push_exp(input int mode);
        if (mode == 2) begin
            repeat (3) exp_q.push_back(mk_frame(0, 1));
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (mode == 1 && i == 2) exp_q.push_back(mk_frame(2, 2));
                exp_q.push_back(mk_frame(i, 3));
            end
        end
    endtask

    // Bus monitor and slave, sampling on the falling clock edge.
    initial begin
        logic       scl, sda, scl_p, sda_p, ack, hi_ok;
        logic [7:0] cur;
        logic [7:0] fb [3];
        logic [25:0] got, e;
        int         hi_len;
        scl_p = 1'b1; sda_p = 1'b1; hi_ok = 1'b0; hi_len = 0; cur = '0;
        fb[0] = '0; fb[1] = '0; fb[2] = '0;
        forever begin
            @(negedge clk);
            scl = i2c_sclk;
            sda = i2c_sdat_in;
            if (!mon_en) begin
                in_frame = 1'b0; hi_ok = 1'b0; bit_cnt = 0; slave_pull = 1'b0;
            end else begin
                if (sda !== sda_p) begin
                    check_val("sda_edge_scl_stable", int'(scl === scl_p), 1);
                    if (scl && scl_p && !sda) begin
                        in_frame = 1'b1; bit_cnt = 0; nbytes = 0; hi_ok = 1'b0;
                        fb[0] = '0; fb[1] = '0; fb[2] = '0;
                        frames++;
                    end else if (scl && scl_p && sda && in_frame) begin
                        got = {2'(nbytes), fb[0], fb[1], fb[2]};
                        if (exp_q.size() == 0) begin
                            n_vec++; n_bad++;
                            $display("FAIL unexpected_frame: got 0x%0h expected no frame", got);
                        end else begin
                            e = exp_q.pop_front();
                            check_val("frame", int'(got), int'(e));
                        end
                        in_frame = 1'b0; hi_ok = 1'b0;
                    end
                end
                if (scl && !scl_p) begin
                    hi_len = 1;
                    hi_ok  = in_frame;
                    if (in_frame) begin
                        if (bit_cnt < 8) begin
                            cur = {cur[6:0], sda};
                            bit_cnt++;
                        end else begin
                            if (nbytes < 3) fb[nbytes] = cur;
                            nbytes++;
                            bit_cnt = 0;
                        end
                    end
                end else if (scl) begin
                    hi_len++;
                end
                if (!scl && scl_p) begin
                    if (hi_ok) check_val("scl_high_cycles", hi_len, 2 * CLK_DIV);
                    hi_ok = 1'b0;
                    if (in_frame && bit_cnt == 8) begin
                        ack = 1'b1;
                        if (nack_mode == 1 && frames == 3 && nbytes == 1 && !nack_used) begin
                            ack = 1'b0;
                            nack_used = 1'b1;
                        end
                        if (nack_mode == 2 && nbytes == 0) ack = 1'b0;
                        slave_pull = ack;
                    end else begin
                        slave_pull = 1'b0;
                    end
                end
            end
            scl_p = scl;
            sda_p = sda;
        end
    end

    task automatic run_vec(input vec_t v, input bit do_push);
        int k;
        bit poked;
        @(negedge clk);
        nack_mode = v.nack_mode;
        nack_used = 1'b0;
        frames    = 0;
        if (do_push) push_exp(v.nack_mode);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        poked = 1'b0;
        check_val("busy_after_start", int'(busy), 1);
        check_val("done_after_start", int'(done), 0);
        check_val("err_after_start", int'(ack_err), 0);
        while (done !== 1'b1 && k < TMO) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (v.poke_frame >= 0 && !poked && frames == v.poke_frame + 1) begin
                start = 1'b1;
                poked = 1'b1;
            end
        end
        start = 1'b0;
        check_val("done_cycle", k, v.exp_done);
        check_val("ack_err", int'(ack_err), int'(v.exp_err));
        check_val("busy_at_done", int'(busy), 0);
        check_val("frames_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        vec_t vtab [4];
        int   k;
        bit   quiet;

        // Clean run: 7 * (116 + GAP_Q) * CLK_DIV + 1.
        vtab[0] = '{0, -1, 1737, 1'b0};
        // Aborted frame adds START + 2 bytes + STOP + gap = 88 quarters.
        vtab[1] = '{1, -1, 1737 + 88 * CLK_DIV, 1'b0};
        // Three address-only attempts of 44 + GAP_Q quarters each.
        vtab[2] = '{2, -1, 3 * (44 + GAP_Q) * CLK_DIV + 1, 1'b1};
        // Rerun from DONE with a start pulse mid-command 3 that must be ignored.
        vtab[3] = '{0, 3, 1737, 1'b0};

        #1;
        check_val("rst_sclk", int'(i2c_sclk), 1);
        check_val("rst_oe", int'(i2c_sdat_oe), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_ack_err", int'(ack_err), 0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (20) @(negedge clk);
        check_val("idle_no_start_busy", int'(busy), 0);

        for (int i = 0; i < 4; i++) run_vec(vtab[i], 1'b1);

        // Reset while byte 0 of command 4 is being shifted.
        @(negedge clk);
        nack_mode = 0;
        frames    = 0;
        push_exp(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(frames == 5 && bit_cnt >= 3) && k < TMO) begin
            @(negedge clk);
            k++;
        end
        check_val("reach_cmd4_bit", int'(k < TMO), 1);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_sclk", int'(i2c_sclk), 1);
        check_val("midrst_oe", int'(i2c_sdat_oe), 0);
        check_val("midrst_busy", int'(busy), 0);
        check_val("midrst_done", int'(done), 0);
        check_val("midrst_frames_left", exp_q.size(), 3);
        exp_q.delete();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (i2c_sclk !== 1'b1 || i2c_sdat_oe !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
                quiet = 1'b0;
        end
        check_val("quiet_after_rst", int'(quiet), 1);
        mon_en = 1'b1;
        @(negedge clk);
        run_vec(vtab[0], 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
